// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: widths, major opcode values seen by the
// control unit, and the fetch-stage state encoding.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
    localparam logic [4:0] OPCODE_STORE   = 5'b01000;
    localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
    localparam logic [4:0] OPCODE_JALR    = 5'b11001;
    localparam logic [4:0] OPCODE_JAL     = 5'b11011;
    localparam logic [4:0] OPCODE_ARITH_I = 5'b00100;
    localparam logic [4:0] OPCODE_ARITH_R = 5'b01100;
    localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
    localparam logic [4:0] OPCODE_LUI     = 5'b01101;
    localparam logic [4:0] OPCODE_SYSTEM  = 5'b11100;
    localparam logic [4:0] OPCODE_CUSTOM  = 5'b00010;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO with flush; the head entry is visible combinationally
// so the consumer can use it in the same cycle it pops.
module fetch_buffer #(
    parameter int unsigned WIDTH = rv_pkg::ILEN + rv_pkg::XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !flush_i && full && !pop_i));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, limits outstanding requests to buffer
// credit, tags returned words with their PC and discards stale words on redirect.
module if_stage #(
    parameter int unsigned     XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [4:0]      id_opcode,
    output logic            id_illegal
);

    import rv_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned BW = ILEN + XLEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   buf_count;
    logic [BW-1:0]   buf_head;
    logic [CW-1:0]   pcq_count;
    logic [XLEN-1:0] pcq_head;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            buf_push;
    logic            id_pop;

    // Responses only count while something is outstanding, so words that
    // straggle in after a reset are ignored.
    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
    assign rsp_drop = rsp_fire && ((discard_q != '0) || redirect_valid);
    assign buf_push = rsp_fire && !rsp_drop;
    assign id_pop   = id_valid && id_ready;

    assign credit_used    = {1'b0, inflight_q} + {1'b0, buf_count} - {{CW{1'b0}}, id_pop};
    assign imem_req_valid = (state_q == ST_RUN) && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr      = pc_q;
    assign inflight_d     = inflight_q + CW'(req_fire) - CW'(rsp_fire);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;

        if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end
        if (rsp_fire && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_DRAIN: state_d = (discard_d == '0) ? ST_RUN : ST_DRAIN;
            default:  state_d = ST_RUN;
        endcase

        // A redirect while draining only retargets the PC; the discard
        // count already covers everything still outstanding.
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            if (state_q != ST_DRAIN) begin
                discard_d = inflight_d;
                state_d   = (inflight_d != '0) ? ST_DRAIN : ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_buffer #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_fire),
        .pop_i   (rsp_fire),
        .flush_i (1'b0),
        .wdata_i (pc_q),
        .rdata_o (pcq_head),
        .count_o (pcq_count)
    );

    fetch_buffer #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (buf_push),
        .pop_i   (id_pop),
        .flush_i (redirect_valid),
        .wdata_i ({imem_rsp_data, pcq_head}),
        .rdata_o (buf_head),
        .count_o (buf_count)
    );

    assign id_valid   = (buf_count != '0);
    assign id_instr   = id_valid ? buf_head[XLEN +: ILEN] : '0;
    assign id_pc      = id_valid ? buf_head[XLEN-1:0] : '0;
    assign id_opcode  = id_instr[6:2];
    assign id_illegal = id_valid && (id_instr[1:0] != 2'b11);

    a_pc_queue_tracks_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        pcq_count == inflight_q);

endmodule
